ntt_stage_scheduler: RTL and testbench
======================================

// Module: ntt_stage_scheduler
// PURPOSE
//  Sequences one full radix-2 NTT/INTT pass over N=2^LOG_N coefficients: walks stage index p, group index k
//  and butterfly index j, issues one butterfly per cycle to the PE array, and drives p/k/conf for the
//  twiddle address generator plus the a/b data-RAM addresses. A drain gap between stages flushes the
//  butterfly pipeline so that read-after-write hazards cannot occur across stages.
// PARAMETERS
//  LOG_N         10  log2 of transform length; p is 0..LOG_N-1, k and j are LOG_N-1 bits wide
//  DRAIN_CYCLES  6   idle cycles after the last issue of every stage (butterfly pipeline depth), >=1
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        start request; sampled only in IDLE
//  conf         in   3        mode; 001 or 100 = NTT, any other nonzero = INTT, 000 = start ignored
//  stall        in   1        holds issue and the counters in RUN
//  busy         out  1        high in RUN, DRAIN and DONE
//  done         out  1        one-cycle pulse when the pass completes
//  issue_valid  out  1        a butterfly is issued this cycle = (state==RUN) & ~stall
//  conf_o       out  3        conf latched at start; drives the twiddle generator
//  p            out  4        current stage index
//  k            out  LOG_N-1  group index within the stage
//  j            out  LOG_N-1  butterfly index within the group
//  addr_a       out  LOG_N    k*2^(p+1) + j
//  addr_b       out  LOG_N    addr_a + 2^p
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy=done=0; conf_o=0; p=k=j=0; drain counter=0.
//  - States: IDLE -> RUN -> DRAIN -> (RUN | DONE) -> IDLE.
//  - IDLE: start=1 and conf!=000 -> latch conf_o and set k=j=0. Set p=LOG_N-1 for NTT, p=0 for INTT. Go to RUN.
//    If conf=000, start is ignored.
//  - RUN: on each cycle with ~stall, issue at the current (p,k,j), then advance:
//      j wraps at 2^p-1 -> j=0, k+1; k wraps at 2^(LOG_N-1-p)-1 -> go to DRAIN.
//      Every stage is exactly 2^(LOG_N-1) issues. While stall=1, all counters hold and issue_valid=0.
//  - DRAIN: counts DRAIN_CYCLES cycles and ignores stall. At the end:
//      if the last stage is finished (p=0 for NTT, p=LOG_N-1 for INTT) -> DONE;
//      otherwise step p (NTT: p-1, INTT: p+1), clear k and j, and go to RUN.
//  - DONE: done=1 for exactly one cycle, then IDLE. p, k, j and conf_o keep their last values.
//  - start while busy is ignored; the conf input is don't-care once latched.
//  - addr_a/addr_b are combinational from p, k, j (LOG_N-bit arithmetic, no overflow by construction).
//    They are valid whenever issue_valid=1.
//  - rst asserted mid-pass aborts immediately to reset values; no done pulse is generated.
//  - Latency with no stall: start sampled at cycle 0, first issue at cycle 1,
//    done at cycle LOG_N*(2^(LOG_N-1)+DRAIN_CYCLES)+1.
// CONFIGURATION
//  SCHED_PERF_CNT_EN defined: adds output port stall_cnt [15:0].
//    - Cleared on rst and on an accepted start; +1 on every RUN cycle with stall=1; saturates at 16'hFFFF.
//    - Holds its value after done.
//  SCHED_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING (LOG_N=10, DRAIN_CYCLES=6)
//  1. Reset mid-RUN (assert rst at cycle 100) -> outputs go to reset values asynchronously; the next start runs a clean pass.
//  2. NTT, conf=001, start at cycle 0, no stall ->
//     - cycle 1: p=9, k=0, j=0, addr_a=0, addr_b=512;
//     - 5120 issues in total; stage p=0 issues addr_a=2k, addr_b=2k+1;
//     - done at cycle 5181 exactly.
//  3. INTT, conf=010 -> p sequence 0,1,...,9; first issue p=0, k=0, j=0, addr (0,1); last issue p=9, k=0, j=511, addr (511,1023).
//  4. Stall=1 for 20 cycles mid-stage -> counters frozen, issue_valid=0; done delayed by exactly 20 cycles;
//     with SCHED_PERF_CNT_EN, stall_cnt=20.
//  5. start with conf=000 -> stays in IDLE, busy=0. start pulsed while busy -> ignored, single done pulse.
//  6. Stall during DRAIN -> has no effect on drain length or on the done cycle.

Source files
------------

// File: rtl/ntt_stage_scheduler_if.sv
// Handshake/bus bundle for ntt_stage_scheduler.
//   master : drives start_i, conf_i and stall_i, and observes the scheduler outputs (testbench or sequencer).
//   slave  : the scheduler itself.
//   Inputs : start_i (start request), conf_i[2:0] (mode), stall_i (freeze issue).
//   Outputs: busy_o, done_o, issue_valid_o, conf_o[2:0], p_o[3:0], k_o/j_o[LOG_N-2:0],
//            addr_a_o/addr_b_o[LOG_N-1:0], and stall_cnt_o[15:0] when SCHED_PERF_CNT_EN is defined.
interface ntt_stage_scheduler_if #(
  parameter int unsigned LOG_N = 10
);
  logic               start_i;
  logic [2:0]         conf_i;
  logic               stall_i;
  logic               busy_o;
  logic               done_o;
  logic               issue_valid_o;
  logic [2:0]         conf_o;
  logic [3:0]         p_o;
  logic [LOG_N-2:0]   k_o;
  logic [LOG_N-2:0]   j_o;
  logic [LOG_N-1:0]   addr_a_o;
  logic [LOG_N-1:0]   addr_b_o;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0]        stall_cnt_o;
`endif

  modport master (
    output start_i, conf_i, stall_i,
`ifdef SCHED_PERF_CNT_EN
    input  stall_cnt_o,
`endif
    input  busy_o, done_o, issue_valid_o, conf_o, p_o, k_o, j_o, addr_a_o, addr_b_o
  );

  modport slave (
    input  start_i, conf_i, stall_i,
`ifdef SCHED_PERF_CNT_EN
    output stall_cnt_o,
`endif
    output busy_o, done_o, issue_valid_o, conf_o, p_o, k_o, j_o, addr_a_o, addr_b_o
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Stage/group/butterfly sequencer for one radix-2 NTT (or INTT) pass over 2^LOG_N coefficients.
// It issues one butterfly per unstalled RUN cycle. It also drives p/k/conf to the twiddle generator and
// the a/b data-RAM addresses. After each stage it inserts DRAIN_CYCLES idle cycles so that the
// butterfly pipeline empties before the next stage reads its results.
// Ports: clk, rst (async, active-high); bus (ntt_stage_scheduler_if.slave), which carries
//   start_i/conf_i/stall_i in, and busy_o/done_o/issue_valid_o/conf_o/p_o/k_o/j_o/addr_a_o/addr_b_o out.
// Option: defining SCHED_PERF_CNT_EN adds bus.stall_cnt_o, a saturating count of stalled RUN cycles.
module ntt_stage_scheduler #(
  parameter int unsigned LOG_N        = 10,
  parameter int unsigned DRAIN_CYCLES = 6
) (
  input logic                   clk,
  input logic                   rst,
  ntt_stage_scheduler_if.slave  bus
);

  localparam int unsigned IdxW   = LOG_N - 1;
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [2:0]        conf_q;
  logic [3:0]        p_q;
  logic [IdxW-1:0]   k_q, j_q;
  logic [DrainW-1:0] drain_q;
  logic              busy_q, done_q;

  logic [LOG_N-1:0]  j_max, k_max, addr_a;
  logic              j_last, k_last, ntt_in, ntt_q, last_stage, drain_end, start_ok;

  always_comb begin
    // The group size is 2^p and the group count is 2^(LOG_N-1-p). These are computed in LOG_N bits
    // so that 2^(LOG_N-1) does not overflow the IdxW-bit counters.
    j_max      = (LOG_N'(1) << p_q) - LOG_N'(1);
    k_max      = (LOG_N'(1) << (IdxW - 32'(p_q))) - LOG_N'(1);
    j_last     = (j_q == j_max[IdxW-1:0]);
    k_last     = (k_q == k_max[IdxW-1:0]);
    ntt_in     = (bus.conf_i == 3'b001) || (bus.conf_i == 3'b100);
    ntt_q      = (conf_q == 3'b001) || (conf_q == 3'b100);
    last_stage = ntt_q ? (p_q == 4'd0) : (p_q == 4'(IdxW));
    drain_end  = (drain_q == DrainW'(DRAIN_CYCLES - 1));
    start_ok   = (state_q == StIdle) && bus.start_i && (bus.conf_i != 3'b000);
    addr_a     = ({1'b0, k_q} << (p_q + 4'd1)) + {1'b0, j_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      conf_q  <= 3'b000;
      p_q     <= 4'd0;
      k_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            conf_q  <= bus.conf_i;
            p_q     <= ntt_in ? 4'(IdxW) : 4'd0;
            k_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!bus.stall_i) begin
            if (j_last && k_last) begin
              // Keep the final (k,j) so they remain visible after the pass ends.
              drain_q <= '0;
              state_q <= StDrain;
            end else if (j_last) begin
              j_q <= '0;
              k_q <= k_q + IdxW'(1);
            end else begin
              j_q <= j_q + IdxW'(1);
            end
          end
        end
        StDrain: begin
          drain_q <= drain_q + DrainW'(1);
          if (drain_end) begin
            drain_q <= '0;
            if (last_stage) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              p_q     <= ntt_q ? (p_q - 4'd1) : (p_q + 4'd1);
              k_q     <= '0;
              j_q     <= '0;
              state_q <= StRun;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (start_ok) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q == StRun) && bus.stall_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  // No stall counter in this build.
`endif

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.issue_valid_o = (state_q == StRun) && !bus.stall_i;
  assign bus.conf_o        = conf_q;
  assign bus.p_o           = p_q;
  assign bus.k_o           = k_q;
  assign bus.j_o           = j_q;
  assign bus.addr_a_o      = addr_a;
  assign bus.addr_b_o      = addr_a + (LOG_N'(1) << p_q);

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Self-checking bench for ntt_stage_scheduler (LOG_N=10, DRAIN_CYCLES=6).
// Expected issue tuples are built from the transform's loop nest. Cycle-level expectations come from
// a stage/drain countdown model, and the done cycle is checked against the closed-form latency.
module tb_ntt_stage_scheduler;

  localparam int unsigned LogN  = 10;
  localparam int unsigned Drain = 6;
  localparam int unsigned Half  = 1 << (LogN - 1);
  localparam int unsigned Bound = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_stage_scheduler_if #(.LOG_N(LogN)) bus ();

  ntt_stage_scheduler #(
    .LOG_N        (LogN),
    .DRAIN_CYCLES (Drain)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] tuple(input int p, input int k, input int j, input int a,
                                        input int b);
    return {4'(p), 12'(k), 12'(j), 16'(a), 16'(b)};
  endfunction

  function automatic logic [63:0] dut_tuple();
    return {4'(bus.p_o), 12'(bus.k_o), 12'(bus.j_o), 16'(bus.addr_a_o), 16'(bus.addr_b_o)};
  endfunction

  // Every butterfly of the pass, in issue order, straight from the loop nest.
  task automatic build_expected(input bit ntt);
    exp_q.delete();
    for (int s = 0; s < int'(LogN); s++) begin
      int p = ntt ? int'(LogN) - 1 - s : s;
      for (int k = 0; k < (1 << (int'(LogN) - 1 - p)); k++) begin
        for (int j = 0; j < (1 << p); j++) begin
          int a = k * (1 << (p + 1)) + j;
          exp_q.push_back(tuple(p, k, j, a, a + (1 << p)));
        end
      end
    end
  endtask

  task automatic run_pass(input logic [2:0] conf, input int stall_pct, input int stall_from,
                          input int stall_len, input int start_pct);
    bit          ntt = (conf == 3'b001) || (conf == 3'b100);
    int          run_left, drain_left, stages_done, stalls, cyc;
    bit          done_now, exp_valid, finished;
    logic [63:0] last_t;
    build_expected(ntt);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.conf_i  = conf;
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    run_left = Half; drain_left = 0; stages_done = 0; stalls = 0;
    done_now = 1'b0; finished = 1'b0; last_t = '0;
    for (cyc = 1; cyc < int'(Bound); cyc++) begin
      bus.start_i = ($urandom_range(99) < start_pct);
      bus.conf_i  = 3'($urandom_range(7));
      bus.stall_i = ($urandom_range(99) < stall_pct) ||
                    (cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clk);
      exp_valid = (run_left > 0) && !bus.stall_i;
      check_eq("issue_valid", bus.issue_valid_o, exp_valid);
      check_eq("busy", bus.busy_o, 1'b1);
      check_eq("done", bus.done_o, done_now);
      if (cyc == 1) check_eq("conf_o", bus.conf_o, conf);
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_issue", 1, 0);
        end else begin
          last_t = exp_q.pop_front();
          check_eq("issue_tuple", dut_tuple(), last_t);
        end
      end
      if (done_now) begin
        check_eq("done_cycle", cyc, LogN * (Half + Drain) + 1 + stalls);
        check_eq("all_issued", exp_q.size(), 0);
        finished = 1'b1;
        break;
      end
      if (run_left > 0) begin
        if (bus.stall_i) stalls++;
        else begin
          run_left--;
          if (run_left == 0) drain_left = Drain;
        end
      end else if (drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) begin
          stages_done++;
          if (stages_done == int'(LogN)) done_now = 1'b1;
          else run_left = Half;
        end
      end
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    if (!finished) check_eq("timeout", 1, 0);
    @(negedge clk);
    check_eq("idle_busy", bus.busy_o, 1'b0);
    check_eq("idle_done", bus.done_o, 1'b0);
    check_eq("hold_conf", bus.conf_o, conf);
    check_eq("hold_pkj", dut_tuple(), last_t);
`ifdef SCHED_PERF_CNT_EN
    check_eq("stall_cnt", bus.stall_cnt_o, stalls);
`endif
  endtask

  initial begin
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.conf_i  = 3'b000;
    bus.stall_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", bus.busy_o, 1'b0);
    check_eq("rst_done", bus.done_o, 1'b0);
    check_eq("rst_conf", bus.conf_o, 3'b000);
    check_eq("rst_pkj", dut_tuple(), tuple(0, 0, 0, 0, 1));
    rst = 1'b0;

    // conf=000 must not start a pass.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.conf_i  = 3'b000;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("conf0_busy", bus.busy_o, 1'b0);
      check_eq("conf0_valid", bus.issue_valid_o, 1'b0);
    end

    run_pass(3'b001, 0, -1, 0, 0);     // NTT, no stall
    run_pass(3'b010, 0, -1, 0, 0);     // INTT, no stall
    run_pass(3'b100, 0, 300, 20, 0);   // 20-cycle stall mid-stage
    run_pass(3'b001, 0, 513, 6, 0);    // stall only during first drain
    run_pass(3'b011, 10, -1, 0, 2);    // random stall and stray starts while busy

    // Reset in the middle of RUN.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.conf_i  = 3'b001;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (99) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_busy", bus.busy_o, 1'b0);
    check_eq("arst_valid", bus.issue_valid_o, 1'b0);
    check_eq("arst_conf", bus.conf_o, 3'b000);
    check_eq("arst_pkj", dut_tuple(), tuple(0, 0, 0, 0, 1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_busy", bus.busy_o, 1'b0);
      check_eq("post_rst_done", bus.done_o, 1'b0);
    end
    run_pass(3'b110, 0, -1, 0, 0);     // clean INTT after abort

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
